// File: rtl/macc_launcher_pkg.sv
// Shared definitions for the MACC launcher: FSM state type, bank sizes and
// the default datapath width.
package macc_launcher_pkg;

    localparam int unsigned DEFAULT_DW   = 32;
    localparam int unsigned NUM_OPERANDS = 10;
    localparam int unsigned NUM_RESULTS  = 4;

    typedef enum logic [1:0] {
        StLoad  = 2'd0,
        StStart = 2'd1,
        StWait  = 2'd2,
        StDrain = 2'd3
    } state_e;

endpackage

// File: rtl/macc_result_skid.sv
// Result stream stage for the MACC launcher: captures the four core results
// into an indexed bank in one cycle, then presents them one word at a time
// from an output register (out1, out2, out3, ap_return), flagging the last.
module macc_result_skid
    import macc_launcher_pkg::*;
#(
    parameter int unsigned DW = DEFAULT_DW
) (
    input  logic          ap_clk,
    input  logic          ap_rst_n,
    input  logic          load,
    input  logic [DW-1:0] load_w0,
    input  logic [DW-1:0] load_w1,
    input  logic [DW-1:0] load_w2,
    input  logic [DW-1:0] load_w3,
    output logic [DW-1:0] res_data,
    output logic          res_valid,
    input  logic          res_ready,
    output logic          res_last,
    output logic          drained
);

    logic [DW-1:0] bank_q [NUM_RESULTS];
    logic [1:0]    rd_idx_q;
    logic [DW-1:0] data_q;
    logic          valid_q;
    logic          last_q;
    logic          pop;

    assign pop      = valid_q & res_ready;
    // Pulses on the cycle the final word is accepted downstream.
    assign drained  = pop & last_q;
    assign res_data  = data_q;
    assign res_valid = valid_q;
    assign res_last  = last_q;

    // Capture all four results at once when the core reports done.
    always_ff @(posedge ap_clk or negedge ap_rst_n) begin
        if (!ap_rst_n) begin
            for (int i = 0; i < NUM_RESULTS; i++) begin
                bank_q[i] <= '0;
            end
        end else if (load) begin
            bank_q[0] <= load_w0;
            bank_q[1] <= load_w1;
            bank_q[2] <= load_w2;
            bank_q[3] <= load_w3;
        end
    end

    // Output register: word 0 is forwarded straight from the load inputs so
    // the stream starts the cycle after capture; later words come from the bank.
    always_ff @(posedge ap_clk or negedge ap_rst_n) begin
        if (!ap_rst_n) begin
            data_q   <= '0;
            valid_q  <= 1'b0;
            last_q   <= 1'b0;
            rd_idx_q <= 2'd0;
        end else if (load) begin
            data_q   <= load_w0;
            valid_q  <= 1'b1;
            last_q   <= 1'b0;
            rd_idx_q <= 2'd1;
        end else if (pop) begin
            if (last_q) begin
                valid_q  <= 1'b0;
                last_q   <= 1'b0;
                rd_idx_q <= 2'd0;
            end else begin
                data_q   <= bank_q[rd_idx_q];
                last_q   <= (rd_idx_q == 2'(NUM_RESULTS - 1));
                rd_idx_q <= rd_idx_q + 2'd1;
            end
        end
    end

endmodule

// File: rtl/macc_launcher.sv
// MACC launcher: gathers ten operands into a registered bank, starts the
// core with an ap_start/ap_ready handshake, captures its four results on
// ap_done and streams them out. Sticky error flags report missing result
// valids and (optionally) a hung core.
// Optional watchdog: define MACC_LAUNCHER_TIMEOUT_EN to bound the WAIT state
// by TIMEOUT_CYCLES and abort on a core that sits idle for two cycles.
module macc_launcher
    import macc_launcher_pkg::*;
#(
    parameter int unsigned DW             = DEFAULT_DW,
    parameter int unsigned TIMEOUT_CYCLES = 64
) (
    input  logic          ap_clk,
    input  logic          ap_rst_n,
    // operand stream
    input  logic [DW-1:0] in_data,
    input  logic          in_valid,
    output logic          in_ready,
    // result stream
    output logic [DW-1:0] res_data,
    output logic          res_valid,
    input  logic          res_ready,
    output logic          res_last,
    // core control
    output logic          ap_start,
    input  logic          ap_done,
    input  logic          ap_idle,
    input  logic          ap_ready,
    // operand bank
    output logic [DW-1:0] core_in1,
    output logic [DW-1:0] core_in2,
    output logic [DW-1:0] core_in3,
    output logic [DW-1:0] core_in4,
    output logic [DW-1:0] core_in5,
    output logic [DW-1:0] core_in6,
    output logic [DW-1:0] core_in7,
    output logic [DW-1:0] core_in8,
    output logic [DW-1:0] core_in9,
    output logic [DW-1:0] core_in10,
    // core results
    input  logic [DW-1:0] out1,
    input  logic [DW-1:0] out2,
    input  logic [DW-1:0] out3,
    input  logic [DW-1:0] ap_return,
    input  logic          out1_ap_vld,
    input  logic          out2_ap_vld,
    input  logic          out3_ap_vld,
    // status
    output logic          busy,
    output logic          err_vld,
    output logic          err_timeout,
    input  logic          err_clr
);

    localparam logic [3:0] IDX_LAST = 4'(NUM_OPERANDS - 1);

    state_e        state_q;
    logic [3:0]    idx_q;
    logic [DW-1:0] core_in_q [NUM_OPERANDS];
    logic          in_ready_q;
    logic          ap_start_q;
    logic          busy_q;
    logic          err_vld_q;

    logic          beat;
    logic          start_entry;
    logic          done_hit;
    logic          abort;
    logic          drained;

    assign beat        = in_valid & in_ready_q;
    assign start_entry = (state_q == StLoad) & beat & (idx_q == IDX_LAST);
    // ap_done and the result valids only matter while waiting on the core.
    assign done_hit    = (state_q == StWait) & ap_done;

    assign in_ready = in_ready_q;
    assign ap_start = ap_start_q;
    assign busy     = busy_q;
    assign err_vld  = err_vld_q;

    assign core_in1  = core_in_q[0];
    assign core_in2  = core_in_q[1];
    assign core_in3  = core_in_q[2];
    assign core_in4  = core_in_q[3];
    assign core_in5  = core_in_q[4];
    assign core_in6  = core_in_q[5];
    assign core_in7  = core_in_q[6];
    assign core_in8  = core_in_q[7];
    assign core_in9  = core_in_q[8];
    assign core_in10 = core_in_q[9];

    // Main control FSM with registered handshake and status outputs.
    always_ff @(posedge ap_clk or negedge ap_rst_n) begin
        if (!ap_rst_n) begin
            state_q    <= StLoad;
            idx_q      <= 4'd0;
            in_ready_q <= 1'b0;
            ap_start_q <= 1'b0;
            busy_q     <= 1'b0;
            for (int i = 0; i < NUM_OPERANDS; i++) begin
                core_in_q[i] <= '0;
            end
        end else begin
            case (state_q)
                StLoad: begin
                    // in_ready rises on the first edge after reset release.
                    in_ready_q <= 1'b1;
                    if (beat) begin
                        for (int i = 0; i < NUM_OPERANDS; i++) begin
                            if (idx_q == 4'(i)) begin
                                core_in_q[i] <= in_data;
                            end
                        end
                        if (idx_q == IDX_LAST) begin
                            idx_q      <= 4'd0;
                            state_q    <= StStart;
                            in_ready_q <= 1'b0;
                            ap_start_q <= 1'b1;
                            busy_q     <= 1'b1;
                        end else begin
                            idx_q <= idx_q + 4'd1;
                        end
                    end
                end
                StStart: begin
                    state_q <= StWait;
                    if (ap_ready) begin
                        ap_start_q <= 1'b0;
                    end
                end
                StWait: begin
                    if (ap_ready) begin
                        ap_start_q <= 1'b0;
                    end
                    if (ap_done) begin
                        // Never leave start asserted into the drain phase.
                        state_q    <= StDrain;
                        ap_start_q <= 1'b0;
                    end else if (abort) begin
                        state_q    <= StLoad;
                        ap_start_q <= 1'b0;
                        busy_q     <= 1'b0;
                        in_ready_q <= 1'b1;
                    end
                end
                StDrain: begin
                    if (drained) begin
                        state_q    <= StLoad;
                        busy_q     <= 1'b0;
                        in_ready_q <= 1'b1;
                    end
                end
                default: begin
                    state_q <= StLoad;
                end
            endcase
        end
    end

    // Sticky missing-valid flag; a new error beats a simultaneous clear.
    always_ff @(posedge ap_clk or negedge ap_rst_n) begin
        if (!ap_rst_n) begin
            err_vld_q <= 1'b0;
        end else if (done_hit && !(out1_ap_vld && out2_ap_vld && out3_ap_vld)) begin
            err_vld_q <= 1'b1;
        end else if (err_clr) begin
            err_vld_q <= 1'b0;
        end
    end

`ifdef MACC_LAUNCHER_TIMEOUT_EN
    localparam int unsigned WD_W = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;

    logic [WD_W-1:0] wd_cnt_q;
    logic            idle_seen_q;
    logic            err_timeout_q;

    // Abort on the last allowed WAIT cycle, or on the second idle cycle in a row.
    assign abort = (state_q == StWait) && !ap_done &&
                   ((wd_cnt_q == WD_W'(TIMEOUT_CYCLES - 1)) || (ap_idle && idle_seen_q));
    assign err_timeout = err_timeout_q;

    // Watchdog counter and idle history, restarted as each run enters START.
    always_ff @(posedge ap_clk or negedge ap_rst_n) begin
        if (!ap_rst_n) begin
            wd_cnt_q    <= '0;
            idle_seen_q <= 1'b0;
        end else if (start_entry) begin
            wd_cnt_q    <= '0;
            idle_seen_q <= 1'b0;
        end else if (state_q == StWait) begin
            wd_cnt_q    <= wd_cnt_q + 1'b1;
            idle_seen_q <= ap_idle;
        end
    end

    // Sticky timeout flag; a new abort beats a simultaneous clear.
    always_ff @(posedge ap_clk or negedge ap_rst_n) begin
        if (!ap_rst_n) begin
            err_timeout_q <= 1'b0;
        end else if (abort) begin
            err_timeout_q <= 1'b1;
        end else if (err_clr) begin
            err_timeout_q <= 1'b0;
        end
    end
`else
    // Unbounded WAIT: no watchdog, ap_idle and TIMEOUT_CYCLES are don't-cares.
    logic unused_cfg;
    assign unused_cfg  = ap_idle ^ (TIMEOUT_CYCLES == 0);
    assign abort       = 1'b0;
    assign err_timeout = 1'b0;
    logic unused_start_entry;
    assign unused_start_entry = start_entry;
`endif

    macc_result_skid #(
        .DW(DW)
    ) u_result_skid (
        .ap_clk   (ap_clk),
        .ap_rst_n (ap_rst_n),
        .load     (done_hit),
        .load_w0  (out1),
        .load_w1  (out2),
        .load_w2  (out3),
        .load_w3  (ap_return),
        .res_data (res_data),
        .res_valid(res_valid),
        .res_ready(res_ready),
        .res_last (res_last),
        .drained  (drained)
    );

endmodule

// File: tb/tb_macc_launcher.sv
// Scoreboard bench for macc_launcher: expected result words are queued when
// the core model reports done and checked by an independent stream monitor.
module tb_macc_launcher;

    localparam int DW = 32;

    logic          ap_clk = 1'b0;
    logic          ap_rst_n = 1'b0;
    logic [DW-1:0] in_data = '0;
    logic          in_valid = 1'b0;
    logic          in_ready;
    logic [DW-1:0] res_data;
    logic          res_valid;
    logic          res_ready = 1'b1;
    logic          res_last;
    logic          ap_start;
    logic          ap_done = 1'b0;
    logic          ap_idle = 1'b0;
    logic          ap_ready = 1'b0;
    logic [DW-1:0] cin [10];
    logic [DW-1:0] out1 = '0, out2 = '0, out3 = '0, ap_return = '0;
    logic          out1_ap_vld = 1'b0, out2_ap_vld = 1'b0, out3_ap_vld = 1'b0;
    logic          busy, err_vld, err_timeout;
    logic          err_clr = 1'b0;

    int n_vec = 0;
    int n_err = 0;
    logic [DW:0] exp_q [$];

    always #5 ap_clk = ~ap_clk;

    macc_launcher #(
        .DW(DW),
        .TIMEOUT_CYCLES(8)
    ) dut (
        .ap_clk(ap_clk), .ap_rst_n(ap_rst_n),
        .in_data(in_data), .in_valid(in_valid), .in_ready(in_ready),
        .res_data(res_data), .res_valid(res_valid), .res_ready(res_ready),
        .res_last(res_last),
        .ap_start(ap_start), .ap_done(ap_done), .ap_idle(ap_idle), .ap_ready(ap_ready),
        .core_in1(cin[0]), .core_in2(cin[1]), .core_in3(cin[2]), .core_in4(cin[3]),
        .core_in5(cin[4]), .core_in6(cin[5]), .core_in7(cin[6]), .core_in8(cin[7]),
        .core_in9(cin[8]), .core_in10(cin[9]),
        .out1(out1), .out2(out2), .out3(out3), .ap_return(ap_return),
        .out1_ap_vld(out1_ap_vld), .out2_ap_vld(out2_ap_vld), .out3_ap_vld(out3_ap_vld),
        .busy(busy), .err_vld(err_vld), .err_timeout(err_timeout), .err_clr(err_clr)
    );

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    // Stream monitor: pops the scoreboard on each accepted word and checks
    // that a stalled word stays put.
    logic [DW-1:0] prev_data = '0;
    logic          prev_stall = 1'b0;
    always @(negedge ap_clk) begin
        if (!ap_rst_n) begin
            prev_stall = 1'b0;
        end else begin
            if (prev_stall) begin
                check("stall_valid_hold", res_valid, 1'b1);
                check("stall_data_hold", res_data, prev_data);
            end
            if (res_valid && res_ready) begin
                if (exp_q.size() == 0) begin
                    check("spurious_word_valid", res_valid, 1'b0);
                end else begin
                    check("res_word", {res_last, res_data}, exp_q.pop_front());
                end
            end
            prev_stall = res_valid && !res_ready;
            prev_data  = res_data;
        end
    end

    task automatic load_ops(input logic [DW-1:0] base);
        for (int i = 0; i < 10; i++) begin
            int t;
            in_valid = 1'b1;
            in_data  = base + DW'(i);
            t = 0;
            @(negedge ap_clk);
            while (!in_ready && t < 50) begin
                @(negedge ap_clk);
                t++;
            end
            if (!in_ready) check("load_in_ready", in_ready, 1'b1);
            @(posedge ap_clk);
            #1;
        end
        in_valid = 1'b0;
        check("start_ap_start", ap_start, 1'b1);
        check("start_busy", busy, 1'b1);
        check("start_in_ready", in_ready, 1'b0);
        for (int i = 0; i < 10; i++) check("core_in", cin[i], base + DW'(i));
    endtask

    task automatic run_core(input int lat, input logic v2, input logic poke,
                            input logic [DW-1:0] r1, input logic [DW-1:0] r2,
                            input logic [DW-1:0] r3, input logic [DW-1:0] r4);
        exp_q.push_back({1'b0, r1});
        exp_q.push_back({1'b0, r2});
        exp_q.push_back({1'b0, r3});
        exp_q.push_back({1'b1, r4});
        if (poke) begin
            in_valid = 1'b1;
            in_data  = 32'hBAD0_BAD0;
        end
        for (int c = 0; c < lat; c++) begin
            @(negedge ap_clk);
            check("ap_start_held", ap_start, 1'b1);
            if (poke) check("in_ready_low_in_run", in_ready, 1'b0);
            @(posedge ap_clk);
            #1;
        end
        in_valid = 1'b0;
        out1 = r1; out2 = r2; out3 = r3; ap_return = r4;
        ap_done = 1'b1; ap_ready = 1'b1;
        out1_ap_vld = 1'b1; out2_ap_vld = v2; out3_ap_vld = 1'b1;
        @(negedge ap_clk);
        check("ap_start_until_ready", ap_start, 1'b1);
        @(posedge ap_clk);
        #1;
        ap_done = 1'b0; ap_ready = 1'b0;
        out1_ap_vld = 1'b0; out2_ap_vld = 1'b0; out3_ap_vld = 1'b0;
        out1 = '0; out2 = '0; out3 = '0; ap_return = '0;
        check("ap_start_dropped", ap_start, 1'b0);
        check("first_word_valid", res_valid, 1'b1);
    endtask

    task automatic wait_idle();
        int t = 0;
        while ((exp_q.size() != 0 || busy) && t < 100) begin
            @(negedge ap_clk);
            t++;
        end
        check("drain_back_to_load_busy", busy, 1'b0);
        check("drain_back_to_load_in_ready", in_ready, 1'b1);
        check("drain_words_left", exp_q.size(), 0);
        @(posedge ap_clk);
        #1;
    endtask

    initial begin
        #200000;
        $display("FAIL global_timeout: simulation did not finish, expected completion");
        $fatal(1);
    end

    initial begin
        // Reset state
        #12;
        check("rst_in_ready", in_ready, 1'b0);
        check("rst_ap_start", ap_start, 1'b0);
        check("rst_busy", busy, 1'b0);
        check("rst_res_valid", res_valid, 1'b0);
        check("rst_res_last", res_last, 1'b0);
        check("rst_res_data", res_data, 0);
        check("rst_core_in1", cin[0], 0);
        check("rst_err_vld", err_vld, 1'b0);
        check("rst_err_timeout", err_timeout, 1'b0);
        #10 ap_rst_n = 1'b1;
        @(posedge ap_clk);
        #1;
        check("post_rst_in_ready", in_ready, 1'b1);

        // Basic run: operands 1..10, results 0x11..0x44
        load_ops(32'd1);
        run_core(4, 1'b1, 1'b0, 32'h11, 32'h22, 32'h33, 32'h44);
        check("clean_err_vld", err_vld, 1'b0);
        wait_idle();

        // Downstream stall mid-drain, operand pokes while waiting on the core
        load_ops(32'h100);
        run_core(4, 1'b1, 1'b1, 32'hA1, 32'hA2, 32'hA3, 32'hA4);
        @(posedge ap_clk);
        #1;
        res_ready = 1'b0;
        repeat (3) @(posedge ap_clk);
        #1;
        res_ready = 1'b1;
        wait_idle();
        check("poke_core_in1_kept", cin[0], 32'h100);
        check("poke_core_in10_kept", cin[9], 32'h109);

        // Missing out2 valid sets a sticky error
        load_ops(32'h200);
        run_core(3, 1'b0, 1'b0, 32'hB1, 32'hB2, 32'hB3, 32'hB4);
        check("err_vld_set", err_vld, 1'b1);
        wait_idle();
        check("err_vld_sticky", err_vld, 1'b1);
        err_clr = 1'b1;
        @(posedge ap_clk);
        #1;
        err_clr = 1'b0;
        check("err_vld_cleared", err_vld, 1'b0);

        // Error and clear in the same cycle: error wins
        load_ops(32'h300);
        err_clr = 1'b1;
        run_core(2, 1'b0, 1'b0, 32'hC1, 32'hC2, 32'hC3, 32'hC4);
        check("err_vld_set_beats_clr", err_vld, 1'b1);
        err_clr = 1'b0;
        wait_idle();
        err_clr = 1'b1;
        @(posedge ap_clk);
        #1;
        err_clr = 1'b0;

        // Reset pulse mid-WAIT, then a stale ap_done
        load_ops(32'h400);
        repeat (2) @(posedge ap_clk);
        #1;
        ap_rst_n = 1'b0;
        #1;
        check("midrst_ap_start", ap_start, 1'b0);
        check("midrst_busy", busy, 1'b0);
        check("midrst_in_ready", in_ready, 1'b0);
        check("midrst_core_in1", cin[0], 0);
        #1 ap_rst_n = 1'b1;
        @(posedge ap_clk);
        #1;
        out1 = 32'hD1; out2 = 32'hD2; out3 = 32'hD3; ap_return = 32'hD4;
        ap_done = 1'b1; ap_ready = 1'b1;
        out1_ap_vld = 1'b1; out2_ap_vld = 1'b1; out3_ap_vld = 1'b1;
        @(posedge ap_clk);
        #1;
        ap_done = 1'b0; ap_ready = 1'b0;
        out1_ap_vld = 1'b0; out2_ap_vld = 1'b0; out3_ap_vld = 1'b0;
        for (int c = 0; c < 3; c++) begin
            @(negedge ap_clk);
            check("stale_done_no_valid", res_valid, 1'b0);
            check("stale_done_in_load", in_ready, 1'b1);
            check("stale_done_busy", busy, 1'b0);
        end
        @(posedge ap_clk);
        #1;

`ifdef MACC_LAUNCHER_TIMEOUT_EN
        // Core never finishes: abort after 8 WAIT cycles
        load_ops(32'h500);
        repeat (8) @(posedge ap_clk);
        #1;
        check("to_not_yet", err_timeout, 1'b0);
        check("to_still_busy", busy, 1'b1);
        @(posedge ap_clk);
        #1;
        check("to_err_timeout", err_timeout, 1'b1);
        check("to_busy", busy, 1'b0);
        check("to_ap_start", ap_start, 1'b0);
        check("to_in_ready", in_ready, 1'b1);
        load_ops(32'h600);
        // Core idle for two WAIT cycles triggers the same abort
        err_clr = 1'b1;
        ap_idle = 1'b1;
        @(posedge ap_clk);
        #1;
        err_clr = 1'b0;
        check("idle_cleared", err_timeout, 1'b0);
        @(posedge ap_clk);
        #1;
        check("idle_first_cycle", busy, 1'b1);
        @(posedge ap_clk);
        #1;
        ap_idle = 1'b0;
        check("idle_err_timeout", err_timeout, 1'b1);
        check("idle_busy", busy, 1'b0);
        @(posedge ap_clk);
        #1;
`endif

        repeat (3) @(posedge ap_clk);
        #1;
        check("scoreboard_empty", exp_q.size(), 0);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/macc_launcher.md
MACC_LAUNCHER -- requirements
Module: macc_launcher

Interface
REQ-001 SHALL have parameter DW, default 32, meaning operand/result word width.
REQ-002 SHALL have parameter TIMEOUT_CYCLES, default 64, meaning the watchdog limit in cycles (used only under REQ-030).
REQ-003 SHALL have port ap_clk, input, 1 bit: the single clock; all logic on its rising edge.
REQ-004 SHALL have port ap_rst_n, input, 1 bit: reset, asynchronous assert, active-low.
REQ-005 SHALL have ports in_data (input, DW), in_valid (input, 1) and in_ready (output, 1): the operand stream.
REQ-006 SHALL have ports res_data (output, DW), res_valid (output, 1), res_ready (input, 1) and res_last (output, 1): the result stream.
REQ-007 SHALL have ports ap_start (output, 1), ap_done (input, 1), ap_idle (input, 1) and ap_ready (input, 1): the core control handshake.
REQ-008 SHALL have ports core_in1..core_in10, output, DW each: the registered operand bank.
REQ-009 SHALL have ports out1, out2, out3 and ap_return (input, DW each) and out1_ap_vld, out2_ap_vld, out3_ap_vld (input, 1 each): the core results.
REQ-010 SHALL have ports busy (output, 1), err_vld (output, 1, sticky), err_timeout (output, 1, sticky) and err_clr (input, 1).

Function
REQ-011 SHALL implement states LOAD, START, WAIT and DRAIN; the reset state is LOAD.
REQ-012 LOAD: in_ready=1; each in_valid&in_ready beat SHALL write core_in[idx] with idx 0..9, then increment idx.
REQ-013 SHALL wrap idx to 0 and move LOAD->START on the same cycle the 10th beat is accepted.
REQ-014 START: ap_start=1; SHALL move to WAIT on the next cycle.
REQ-015 SHALL hold ap_start high in both START and WAIT until the cycle ap_ready=1 is sampled, and drive it 0 from the following cycle.
REQ-016 WAIT: on ap_done=1, SHALL capture out1, out2, out3 and ap_return into a 4-entry result bank and move to DRAIN.
REQ-017 On the ap_done cycle, if any outN_ap_vld=0, SHALL still capture all values and set err_vld.
REQ-018 DRAIN: SHALL emit the bank in order out1, out2, out3, ap_return with res_valid=1 and res_last=1 on the 4th word only.
REQ-019 SHALL advance the DRAIN word index only on res_valid&res_ready, and hold res_data and res_valid stable otherwise.
REQ-020 After the 4th accepted word, SHALL move DRAIN->LOAD on the next cycle; throughput is one result word per cycle under full readiness.
REQ-021 in_ready SHALL be 0 in every state other than LOAD, so that operands are never overwritten mid-run.
REQ-022 SHALL ignore ap_done and all outN_ap_vld outside WAIT.
REQ-023 busy SHALL be 1 in every state except LOAD.
REQ-024 err_clr=1 SHALL clear both sticky flags; a flag set and err_clr in the same cycle SHALL leave the flag set.
REQ-025 ap_idle SHALL be unused except under REQ-031.

Reset
REQ-026 ap_rst_n=0 SHALL immediately force state LOAD, idx=0, ap_start=0, in_ready=0 (while reset is asserted), res_valid=0, res_last=0, res_data=0, core_in1..10=0, busy=0 and both err flags 0.
REQ-027 Reset asserted mid-WAIT or mid-DRAIN SHALL abandon the run; a later ap_done SHALL be ignored (REQ-022).
REQ-028 Release of ap_rst_n SHALL take effect synchronously on the next ap_clk edge.

Configuration
REQ-029 The compile-time macro for this block SHALL be MACC_LAUNCHER_TIMEOUT_EN.
REQ-030 With MACC_LAUNCHER_TIMEOUT_EN defined, a cycle counter SHALL run in WAIT and clear on entry to START; when it reaches TIMEOUT_CYCLES without ap_done, the block SHALL set err_timeout, drop ap_start, and return to LOAD, discarding the run.
REQ-031 Under REQ-030, a core that shows ap_idle=1 for 2 consecutive cycles in WAIT SHALL trigger the same abort as a timeout.
REQ-032 Without MACC_LAUNCHER_TIMEOUT_EN, WAIT SHALL be unbounded, err_timeout SHALL be tied 0, and no counter logic SHALL be present.

Structure
REQ-033 A shared package SHALL hold the state enum, NUM_OPERANDS=10, NUM_RESULTS=4 and the default DW.
REQ-034 The result stream output SHALL be a single sub-module, macc_result_skid, implemented as a 4-entry indexed bank plus output register.

Verification
REQ-035 Operands 1..10 fed back-to-back, core model returning done after 4 cycles with out1=0x11, out2=0x22, out3=0x33, ap_return=0x44 -> core_in1..10=1..10, ap_start high exactly until ap_ready, res_data 0x11,0x22,0x33,0x44 with res_last only on 0x44.
REQ-036 res_ready held low for 3 cycles during DRAIN -> res_data and res_valid stable for those cycles, no word lost or duplicated.
REQ-037 in_valid=1 during WAIT -> in_ready=0 and core_in unchanged.
REQ-038 out2_ap_vld=0 on the ap_done cycle -> err_vld=1 and stays set until err_clr.
REQ-039 ap_rst_n pulsed low mid-WAIT, then ap_done arrives -> ap_start=0 immediately, no res_valid, state LOAD.
REQ-040 With MACC_LAUNCHER_TIMEOUT_EN defined, TIMEOUT_CYCLES=8 and a core that never returns done -> err_timeout=1 after 8 WAIT cycles, busy=0, and the next 10 operands are accepted.
